// File: rtl/wb_uart_regs.sv
// wb_uart_regs
// Wishbone classic slave register bank between the bus and the UART FIFOs.
// Bus writes to TXDATA become TX FIFO pushes and bus reads of RXDATA become
// RX FIFO pops. The block also holds sticky overflow/overrun flags and the
// interrupt enables, and drives one registered level interrupt.
// Every side effect is committed on the accept edge. Ack, push and pop
// strobes are asserted for the single cycle that follows that edge.

module wb_uart_regs #(
   parameter int DATA_BITS = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   // Wishbone classic slave
   input  logic                 i_wb_cyc,
   input  logic                 i_wb_stb,
   input  logic                 i_wb_we,
   input  logic [1:0]           i_wb_adr,
   input  logic [31:0]          i_wb_dat,
   output logic [31:0]          o_wb_dat,
   output logic                 o_wb_ack,
   // TX FIFO write side
   output logic [DATA_BITS-1:0] o_tx_data,
   output logic                 o_tx_write,
   input  logic                 i_tx_full,
   input  logic                 i_tx_empty,
   // RX FIFO read side
   input  logic [DATA_BITS-1:0] i_rx_data,
   output logic                 o_rx_read,
   input  logic                 i_rx_full,
   input  logic                 i_rx_empty,
   input  logic                 i_rx_push,
   // interrupt
   output logic                 o_irq
);

   // Register word addresses
   localparam logic [1:0] ADR_TXDATA = 2'd0;
   localparam logic [1:0] ADR_RXDATA = 2'd1;
   localparam logic [1:0] ADR_STATUS = 2'd2;
   localparam logic [1:0] ADR_CTRL   = 2'd3;

   // Bit positions inside STATUS and CTRL
   localparam int ST_TX_OVF = 4;
   localparam int ST_RX_OVR = 5;
   localparam int CT_RX_IE  = 0;
   localparam int CT_TX_IE  = 1;
   localparam int CT_ERR_IE = 2;

   // Bus-facing state
   logic                 r_ack;
   logic [31:0]          r_rd_dat;
   logic                 r_tx_write;
   logic [DATA_BITS-1:0] r_tx_data;
   logic                 r_rx_read;
   logic                 r_irq;

   // Programmer-visible state
   logic [2:0]           r_ctrl;
   logic                 r_tx_ovf;
   logic                 r_rx_ovr;

   // Decoded per-accept actions
   logic                 w_accept;
   logic                 w_tx_push;
   logic                 w_rx_pop;
   logic                 w_ctrl_wr;
   logic                 w_tx_ovf_set;
   logic                 w_tx_ovf_clr;
   logic                 w_rx_ovr_set;
   logic                 w_rx_ovr_clr;
   logic [31:0]          w_rd_data;
   logic                 w_irq_next;

   // Only a handful of the write-data bits land in registers. The rest are
   // folded into this name so that they read as deliberately unused.
   logic                 w_unused;
   assign w_unused = ^i_wb_dat;

   // The ack register itself blocks a new accept, so a master that holds
   // cyc/stb high gets one transaction every two cycles.
   assign w_accept = i_wb_cyc & i_wb_stb & ~r_ack;

   // An overrun is noticed whenever the receiver pushes into a full FIFO,
   // whether or not a bus cycle is in progress.
   assign w_rx_ovr_set = i_rx_push & i_rx_full;

   // Decode the accepted access into push/pop/W1C/CTRL-write actions
   always_comb begin
      w_tx_push    = 1'b0;
      w_rx_pop     = 1'b0;
      w_ctrl_wr    = 1'b0;
      w_tx_ovf_set = 1'b0;
      w_tx_ovf_clr = 1'b0;
      w_rx_ovr_clr = 1'b0;
      if (w_accept) begin
         case (i_wb_adr)
            ADR_TXDATA: begin
               if (i_wb_we) begin
                  // A byte written while the FIFO is full is dropped and
                  // only leaves a trace in tx_ovf.
                  if (i_tx_full) begin
                     w_tx_ovf_set = 1'b1;
                  end else begin
                     w_tx_push = 1'b1;
                  end
               end
            end
            ADR_RXDATA: begin
               // Pop only when the head is valid, so an empty read has no
               // side effect on the FIFO.
               if (!i_wb_we && !i_rx_empty) begin
                  w_rx_pop = 1'b1;
               end
            end
            ADR_STATUS: begin
               if (i_wb_we) begin
                  w_tx_ovf_clr = i_wb_dat[ST_TX_OVF];
                  w_rx_ovr_clr = i_wb_dat[ST_RX_OVR];
               end
            end
            default: begin
               if (i_wb_we) begin
                  w_ctrl_wr = 1'b1;
               end
            end
         endcase
      end
   end

   // Read-data mux, sampled into o_wb_dat on a read accept
   always_comb begin
      w_rd_data = '0;
      case (i_wb_adr)
         ADR_RXDATA: begin
            if (!i_rx_empty) begin
               w_rd_data = {1'b1, {(31-DATA_BITS){1'b0}}, i_rx_data};
            end
         end
         ADR_STATUS: begin
            w_rd_data[0]         = i_tx_full;
            w_rd_data[1]         = i_tx_empty;
            w_rd_data[2]         = i_rx_full;
            w_rd_data[3]         = ~i_rx_empty;
            w_rd_data[ST_TX_OVF] = r_tx_ovf;
            w_rd_data[ST_RX_OVR] = r_rx_ovr;
         end
         ADR_CTRL: begin
            w_rd_data[2:0] = r_ctrl;
         end
         default: begin
            // TXDATA reads back as zero
            w_rd_data = '0;
         end
      endcase
   end

   // Interrupt source, computed from current enables, FIFO levels and flags
   always_comb begin
      w_irq_next = (r_ctrl[CT_RX_IE]  & ~i_rx_empty)
                 | (r_ctrl[CT_TX_IE]  &  i_tx_empty)
                 | (r_ctrl[CT_ERR_IE] & (r_tx_ovf | r_rx_ovr));
   end

   // Bus handshake: ack, strobes and the data registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ack      <= 1'b0;
         r_rd_dat   <= '0;
         r_tx_write <= 1'b0;
         r_tx_data  <= '0;
         r_rx_read  <= 1'b0;
      end else begin
         r_ack      <= w_accept;
         r_tx_write <= w_tx_push;
         r_rx_read  <= w_rx_pop;
         if (w_tx_push) begin
            r_tx_data <= i_wb_dat[DATA_BITS-1:0];
         end
         // Read data holds between reads so a slow master can still see it
         if (w_accept && !i_wb_we) begin
            r_rd_dat <= w_rd_data;
         end
      end
   end

   // CTRL register and sticky error flags. A set wins over a W1C clear in
   // the same cycle, so no error event is ever lost.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ctrl   <= '0;
         r_tx_ovf <= 1'b0;
         r_rx_ovr <= 1'b0;
      end else begin
         if (w_ctrl_wr) begin
            r_ctrl <= i_wb_dat[2:0];
         end
         r_tx_ovf <= w_tx_ovf_set | (r_tx_ovf & ~w_tx_ovf_clr);
         r_rx_ovr <= w_rx_ovr_set | (r_rx_ovr & ~w_rx_ovr_clr);
      end
   end

   // Registered level interrupt, lagging its sources by one cycle
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= w_irq_next;
      end
   end

   assign o_wb_ack   = r_ack;
   assign o_wb_dat   = r_rd_dat;
   assign o_tx_write = r_tx_write;
   assign o_tx_data  = r_tx_data;
   assign o_rx_read  = r_rx_read;
   assign o_irq      = r_irq;

endmodule

// File: tb/tb_wb_uart_regs.sv
// tb_wb_uart_regs
// Directed test of the UART Wishbone register bank, with hand-computed
// expected values. The bench drives inputs on the falling edge and samples
// the DUT 1 ns after the rising edge.

`timescale 1ns/1ps

module tb_wb_uart_regs;

   localparam int DATA_BITS = 8;

   logic                 clk;
   logic                 rst_n;
   logic                 cyc, stb, we;
   logic [1:0]           adr;
   logic [31:0]          wdat;
   logic [31:0]          rdat;
   logic                 ack;
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_write;
   logic                 tx_full, tx_empty;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_read;
   logic                 rx_full, rx_empty, rx_push;
   logic                 irq;

   int errors = 0;
   int checks = 0;

   // Outputs captured in the ack cycle (s_*) and in the cycle after it (a_*)
   logic        s_ack, s_txw, s_rxr, s_irq;
   logic [31:0] s_dat, s_txd;
   logic        a_ack, a_txw, a_rxr, a_irq;

   wb_uart_regs #(.DATA_BITS(DATA_BITS)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_wb_cyc   (cyc),
      .i_wb_stb   (stb),
      .i_wb_we    (we),
      .i_wb_adr   (adr),
      .i_wb_dat   (wdat),
      .o_wb_dat   (rdat),
      .o_wb_ack   (ack),
      .o_tx_data  (tx_data),
      .o_tx_write (tx_write),
      .i_tx_full  (tx_full),
      .i_tx_empty (tx_empty),
      .i_rx_data  (rx_data),
      .o_rx_read  (rx_read),
      .i_rx_full  (rx_full),
      .i_rx_empty (rx_empty),
      .i_rx_push  (rx_push),
      .o_irq      (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One Wishbone transaction; the bench drops cyc/stb during the ack cycle
   task automatic wb_xfer(input logic t_we, input logic [1:0] t_adr, input logic [31:0] t_dat);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = t_we; adr = t_adr; wdat = t_dat;
      @(posedge clk); #1;
      s_ack = ack; s_dat = rdat; s_txw = tx_write; s_txd = 32'(tx_data);
      s_rxr = rx_read; s_irq = irq;
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(posedge clk); #1;
      a_ack = ack; a_txw = tx_write; a_rxr = rx_read; a_irq = irq;
   endtask

   initial begin
      logic [7:0] ack_vec;
      int         pushes;

      rst_n = 1'b0; cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 2'd0; wdat = 32'h11;
      tx_full = 1'b0; tx_empty = 1'b1; rx_data = '0; rx_full = 1'b0;
      rx_empty = 1'b1; rx_push = 1'b0;

      // Held in reset with a strobe asserted: all outputs must stay at zero
      repeat (3) @(posedge clk);
      #1;
      check("rst_ack",  32'(ack), 32'h0);
      check("rst_dat",  rdat, 32'h0);
      check("rst_txw",  32'(tx_write), 32'h0);
      check("rst_txd",  32'(tx_data), 32'h0);
      check("rst_rxr",  32'(rx_read), 32'h0);
      check("rst_irq",  32'(irq), 32'h0);
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      rst_n = 1'b1;

      wb_xfer(1'b0, 2'd3, 32'h0);
      check("ctrl_after_rst", s_dat, 32'h0);
      wb_xfer(1'b0, 2'd2, 32'h0);
      check("status_after_rst", s_dat, 32'h0000_0002);

      // TX push with room in the FIFO
      wb_xfer(1'b1, 2'd0, 32'h0000_005A);
      check("tx_ack",       32'(s_ack), 32'h1);
      check("tx_write",     32'(s_txw), 32'h1);
      check("tx_data",      s_txd, 32'h5A);
      check("tx_ack_once",  32'(a_ack), 32'h0);
      check("tx_write_once",32'(a_txw), 32'h0);

      // TX push into a full FIFO: the byte is dropped and tx_ovf is set
      tx_full = 1'b1; tx_empty = 1'b0;
      wb_xfer(1'b1, 2'd0, 32'h0000_0077);
      check("txf_ack",   32'(s_ack), 32'h1);
      check("txf_write", 32'(s_txw), 32'h0);
      check("txf_data",  s_txd, 32'h5A);
      wb_xfer(1'b0, 2'd2, 32'h0);
      check("status_txovf", s_dat, 32'h0000_0011);
      wb_xfer(1'b1, 2'd2, 32'h0000_0010);
      wb_xfer(1'b0, 2'd2, 32'h0);
      check("status_txovf_clr", s_dat, 32'h0000_0001);
      tx_full = 1'b0;

      // RX pop of a valid byte, then a read of an empty FIFO
      rx_data = 8'hC3; rx_empty = 1'b0;
      wb_xfer(1'b0, 2'd1, 32'h0);
      check("rx_dat",      s_dat, 32'h8000_00C3);
      check("rx_read",     32'(s_rxr), 32'h1);
      check("rx_read_once",32'(a_rxr), 32'h0);
      rx_empty = 1'b1;
      wb_xfer(1'b0, 2'd1, 32'h0);
      check("rx_empty_dat",  s_dat, 32'h0);
      check("rx_empty_read", 32'(s_rxr), 32'h0);
      wb_xfer(1'b0, 2'd0, 32'h0);
      check("txdata_reads0", s_dat, 32'h0);

      // Overrun flag, its W1C, and a set that collides with the clear
      @(negedge clk);
      rx_full = 1'b1; rx_push = 1'b1;
      @(negedge clk);
      rx_full = 1'b0; rx_push = 1'b0;
      wb_xfer(1'b0, 2'd2, 32'h0);
      check("status_rxovr", s_dat, 32'h0000_0020);
      wb_xfer(1'b1, 2'd2, 32'h0000_0020);
      wb_xfer(1'b0, 2'd2, 32'h0);
      check("status_rxovr_clr", s_dat, 32'h0);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 2'd2; wdat = 32'h0000_0020;
      rx_full = 1'b1; rx_push = 1'b1;
      @(posedge clk); #1;
      check("w1c_collide_ack", 32'(ack), 32'h1);
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0; we = 1'b0; rx_full = 1'b0; rx_push = 1'b0;
      wb_xfer(1'b0, 2'd2, 32'h0);
      check("set_wins", s_dat, 32'h0000_0020);
      wb_xfer(1'b1, 2'd2, 32'h0000_0030);

      // rx interrupt: o_irq follows i_rx_empty falling by one clock
      wb_xfer(1'b1, 2'd3, 32'h0000_0001);
      @(negedge clk);
      rx_empty = 1'b0;
      #1;
      check("irq_rx_before", 32'(irq), 32'h0);
      @(posedge clk); #1;
      check("irq_rx_after", 32'(irq), 32'h1);
      rx_empty = 1'b1;
      wb_xfer(1'b0, 2'd3, 32'h0);
      check("ctrl_read1", s_dat, 32'h0000_0001);

      // error interrupt via tx_ovf, then clear it
      wb_xfer(1'b1, 2'd3, 32'h0000_0004);
      tx_full = 1'b1;
      wb_xfer(1'b1, 2'd0, 32'h0000_0099);
      check("irq_err_set", 32'(a_irq), 32'h1);
      tx_full = 1'b0;
      wb_xfer(1'b1, 2'd2, 32'h0000_0010);
      check("irq_err_ackcyc", 32'(s_irq), 32'h1);
      check("irq_err_clr",    32'(a_irq), 32'h0);

      // tx interrupt from an empty TX FIFO
      tx_empty = 1'b1;
      wb_xfer(1'b1, 2'd3, 32'h0000_0002);
      check("irq_tx_on", 32'(a_irq), 32'h1);
      wb_xfer(1'b1, 2'd3, 32'h0000_0000);
      check("irq_tx_off", 32'(a_irq), 32'h0);

      // cyc/stb held high for four TXDATA writes: acks in alternate cycles
      ack_vec = '0; pushes = 0;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 2'd0; wdat = 32'h0000_0033;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         ack_vec = {ack_vec[6:0], ack};
         if (tx_write) pushes++;
      end
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(posedge clk); #1;
      if (tx_write) pushes++;
      check("b2b_ack_pattern", 32'(ack_vec), 32'h0000_00AA);
      check("b2b_pushes",      32'(pushes), 32'd4);
      check("b2b_tx_data",     32'(tx_data), 32'h33);

      // Reset asserted during a transaction aborts it
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 2'd0; wdat = 32'h0000_0044;
      #1 rst_n = 1'b0;
      @(posedge clk); #1;
      check("abort_ack_in_rst", 32'(ack), 32'h0);
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("abort_no_ack",  32'(ack), 32'h0);
      check("abort_no_push", 32'(tx_write), 32'h0);
      check("abort_txd_rst", 32'(tx_data), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wb_uart_regs.md
# wb_uart_regs

Wishbone classic slave register bank that sits directly upstream of the UART TX FIFO and downstream of the UART RX FIFO. It turns bus writes into TX FIFO pushes and bus reads into RX FIFO pops. It exposes FIFO status, sticky error flags and interrupt enables, and drives a single level interrupt. This block replaces the constant TX data source in the UART top level.

## Interface
Parameters:
- DATA_BITS, 8, UART character width; must be ≤ 24.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_wb_cyc, i_wb_stb, i_wb_we  in  1 each  Wishbone classic strobes
- i_wb_adr  in  2  word address of the register
- i_wb_dat  in  32  write data
- o_wb_dat  out  32  read data, valid while o_wb_ack is high
- o_wb_ack  out  1  one-cycle acknowledge
- o_tx_data  out  DATA_BITS  byte to push into the TX FIFO
- o_tx_write  out  1  one-cycle TX FIFO push strobe
- i_tx_full, i_tx_empty  in  1 each  TX FIFO status
- i_rx_data  in  DATA_BITS  RX FIFO head data
- o_rx_read  out  1  one-cycle RX FIFO pop strobe
- i_rx_full, i_rx_empty  in  1 each  RX FIFO status
- i_rx_push  in  1  RX FIFO write strobe from the receiver, used for overrun detection
- o_irq  out  1  registered level interrupt

## Operation
- Register map (word address):
  - 0 TXDATA
    - Write: push i_wb_dat[DATA_BITS-1:0].
    - If i_tx_full is high at accept, the byte is dropped, no o_tx_write is issued, and tx_ovf is set.
    - Reads as 0.
  - 1 RXDATA
    - Read: bit 31 = valid (= !i_rx_empty at accept); bits [DATA_BITS-1:0] = i_rx_data if valid, else 0.
    - A pop is issued only if valid.
    - Writes are ignored.
  - 2 STATUS
    - Read bits: 0 tx_full, 1 tx_empty, 2 rx_full, 3 rx_avail (= !i_rx_empty), 4 tx_ovf, 5 rx_ovr.
    - Write: 1 in bit 4 or bit 5 clears that flag (W1C); other bits are ignored.
  - 3 CTRL
    - R/W: bit 0 rx_ie, bit 1 tx_ie, bit 2 err_ie.
- Unused read bits return 0.
- rx_ovr is set on any cycle where i_rx_push && i_rx_full.
- If a set event and a W1C clear of the same flag occur in the same cycle, set wins.
- Interrupt, registered every cycle: o_irq <= (rx_ie & !i_rx_empty) | (tx_ie & i_tx_empty) | (err_ie & (tx_ovf | rx_ovr)).
- Reset values:
  - o_wb_ack, o_wb_dat, o_tx_write, o_tx_data, o_rx_read, o_irq all 0.
  - CTRL = 0, tx_ovf = 0, rx_ovr = 0.
- Reset asserted mid-transaction aborts it. No ack, push or pop follows after reset is released.

## Timing
- Accept condition: i_wb_cyc & i_wb_stb & !o_wb_ack on a rising edge. All register and status sampling happens on this accept edge.
- Ack timing:
  - o_wb_ack is high for exactly the one cycle after the accept edge.
  - The next accept is possible in the cycle after ack, so peak throughput is one transaction per 2 cycles.
- o_wb_dat is registered at accept and holds its value until the next read accept.
- o_tx_write and o_rx_read pulse in the ack cycle, coincident with o_wb_ack. o_tx_data is registered at accept.
- Side effects are committed at accept. If the master drops i_wb_cyc before ack, the push, pop or W1C still occurs and ack is still driven.
- Back-to-back RXDATA reads see the FIFO head already advanced by the prior pop, because the FIFO updates on the pop edge.
- o_irq lags its source conditions by one cycle.

## Test plan
- Reset: hold i_rst_n = 0 with stb high -> all outputs 0, no ack. Release reset -> CTRL reads 0x0 and STATUS bits 4–5 read 0.
- TX push: write 0x5A to addr 0 with i_tx_full = 0 -> ack 1 cycle later, o_tx_write for 1 cycle with o_tx_data = 0x5A. Repeat with i_tx_full = 1 -> no push, STATUS bit 4 = 1.
- RX pop: i_rx_data = 0xC3, i_rx_empty = 0, read addr 1 -> o_wb_dat = 0x800000C3, single o_rx_read pulse. Same read with i_rx_empty = 1 -> 0x00000000 and no pop.
- Overrun and W1C:
  - Pulse i_rx_push with i_rx_full = 1 -> STATUS bit 5 = 1.
  - Write 0x20 to addr 2 -> bit 5 cleared.
  - Repeat the W1C in the same cycle as a push into a full FIFO -> bit 5 stays 1.
- IRQ:
  - CTRL = 0x1 and i_rx_empty falls -> o_irq rises one cycle later.
  - CTRL = 0x4 with tx_ovf set -> o_irq = 1; clearing tx_ovf -> o_irq = 0 the cycle after.
- Handshake: hold cyc/stb high continuously for 4 TXDATA writes -> acks in alternate cycles, exactly 4 o_tx_write pulses.
